tdc_frame_rx: RTL
=================

Name: tdc_frame_rx

Overview:
- Receive end of the TDC capture dump link. Deserialises the 8N1 UART stream that the TDC top emits and rebuilds each 128-bit echo capture array.
- Wire format: one frame is FRAME_BITS ASCII characters, each '0' (0x30) or '1' (0x31). Character k is array bit k, with bit 0 sent first. The frame ends with CR (0x0D) then LF (0x0A).
- Used on a second board, or in loopback on the same board, to check the dump and to present the capture in parallel form to downstream logic.

Parameters:
- BAUD_DIV, 868, clk100 cycles per UART bit (115200 baud at 100 MHz); legal range 16..4095.
- FRAME_BITS, 128, number of data characters per frame; legal range 1..255.

Ports:
- clk100  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input; idle level is high.
- rx_byte  out  8  last byte received with a good stop bit.
- byte_ready  out  1  one-cycle pulse; rx_byte is valid on this cycle.
- frame  out  FRAME_BITS  last good frame; frame[k] = character k.
- ones_count  out  8  number of '1' characters in the last good frame.
- frame_valid  out  1  one-cycle pulse when frame and ones_count update.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- err_code  out  2  cause of the last abort, held until the next abort: 0 = UART stop-bit error; 1 = illegal character; 2 = wrong character count; 3 = missing LF after CR.

Behaviour:
- Reset: every output, counter and state register goes to 0. The parser goes to HUNT. The UART goes to IDLE.
- Input sync: rx passes through a 2-flop synchroniser. The synchronisers are reset to 1.
- UART states and transitions:
  - IDLE -> START on a 1->0 transition of the synchronised rx.
  - START: wait BAUD_DIV/2 cycles, then resample. Low -> DATA. High -> IDLE (glitch, no error).
  - DATA: sample 8 bits, LSB first, each BAUD_DIV cycles apart.
  - STOP: sample BAUD_DIV cycles after the last data bit.
  - Stop bit = 1: pulse byte_ready and update rx_byte on the next cycle, then -> IDLE.
  - Stop bit = 0: give a stop-bit error to the parser (no byte_ready), then -> IDLE. A new start bit is searched for starting on the following cycle.
- Parser: acts only on byte_ready or a stop-bit error. Bytes are handled in the same cycle they arrive.
  - HUNT: discard all bytes. LF -> DATA, with index = 0 and count = 0. HUNT never raises frame_err.
  - DATA:
    - '0' or '1': write the bit into the shadow register at index; count += 1 on '1'; index += 1.
    - CR with index == FRAME_BITS -> LFWAIT.
    - CR with index != FRAME_BITS -> error code 2.
    - A data character when index == FRAME_BITS -> error code 2 (overrun).
    - Any other byte -> error code 1.
  - LFWAIT: LF -> copy the shadow register to frame and count to ones_count, pulse frame_valid one cycle after the LF byte_ready, then -> DATA with index and count cleared (back-to-back frames need no re-hunt). Any other byte -> error code 3.
  - Any state except HUNT, on a stop-bit error -> error code 0.
  - On any error: pulse frame_err, latch err_code, -> HUNT. frame and ones_count keep their previous values.
  - frame_valid and frame_err are never asserted in the same cycle.
- Width rules:
  - index is 8 bits and is compared against FRAME_BITS.
  - ones_count is 8 bits; the maximum value 128 fits.
  - The shadow register is written only through the index; no shift register is used.
- Reset mid-frame: the partial frame is lost and no pulse is produced. After reset the first frame is always discarded while the parser hunts for LF.

Test Plan:
- Reset, then send LF followed by a frame of 0x00..0FF pattern "0101…" (128 chars) + CR LF -> one frame_valid; frame = 128'hAAAA…AAAA; ones_count = 64; frame_err never pulses.
- Reset, then send a frame with no leading LF -> no frame_valid. Then send the same frame again -> frame_valid with the correct value.
- After sync, send two back-to-back frames, all '1' then all '0' -> two frame_valid pulses: first frame all ones with ones_count = 128, then frame = 0 with ones_count = 0.
- Send 127 chars + CR -> frame_err with err_code = 2; frame keeps its old value. Send a valid frame next -> recovered only after an LF has been seen.
- Send 'X' (0x58) at position 5 -> frame_err, err_code = 1. Send CR followed by 0x30 -> err_code = 3.
- Hold rx low through the stop bit (break) -> frame_err, err_code = 0, no byte_ready. Pulse rx low for BAUD_DIV/4 cycles -> no byte_ready and no error. Assert reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/tdc_frame_rx_if.sv
// Signal bundle for the TDC capture-dump receiver: serial input plus the
// parallel byte and frame results it produces.
interface tdc_frame_rx_if #(
    parameter int FRAME_BITS = 128
);
    logic                  rx;
    logic [7:0]            rx_byte;
    logic                  byte_ready;
    logic [FRAME_BITS-1:0] frame;
    logic [7:0]            ones_count;
    logic                  frame_valid;
    logic                  frame_err;
    logic [1:0]            err_code;

    // Source side: drives the serial line, observes the decoded results.
    modport master (
        output rx,
        input  rx_byte, byte_ready, frame, ones_count,
        input  frame_valid, frame_err, err_code
    );

    // Receiver side: consumes the serial line, produces the decoded results.
    modport slave (
        input  rx,
        output rx_byte, byte_ready, frame, ones_count,
        output frame_valid, frame_err, err_code
    );
endinterface

// File: rtl/tdc_frame_rx.sv
// Receive end of the TDC capture dump link: 8N1 UART deserialiser followed by
// a frame parser that rebuilds the capture array from '0'/'1' characters
// terminated by CR LF.
module tdc_frame_rx #(
    parameter int BAUD_DIV   = 868,
    parameter int FRAME_BITS = 128
) (
    input logic           clk100,
    input logic           reset,
    tdc_frame_rx_if.slave bus
);
    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
    localparam logic [7:0]  FB8       = 8'(FRAME_BITS);
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [7:0]  CH_CR     = 8'h0D;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_HUNT, P_DATA, P_LFWAIT} parse_state_t;

    logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
    uart_state_t           ustate_reg;
    logic [11:0]           baud_cnt_reg;
    logic [2:0]            bit_idx_reg;
    logic [7:0]            shift_reg;
    logic [7:0]            rx_byte_reg;
    logic                  byte_ready_reg;
    logic                  stop_err_reg;

    parse_state_t          pstate_reg;
    logic [7:0]            idx_reg;
    logic [7:0]            count_reg;
    logic [FRAME_BITS-1:0] shadow_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [7:0]            ones_reg;
    logic                  frame_valid_reg;
    logic                  frame_err_reg;
    logic [1:0]            err_code_reg;

    logic                  is_data;
    logic                  shadow_we;

    assign is_data   = (rx_byte_reg == 8'h30) || (rx_byte_reg == 8'h31);
    assign shadow_we = byte_ready_reg && !stop_err_reg && (pstate_reg == P_DATA)
                       && is_data && (idx_reg != FB8);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection;
    // idles high so reset never looks like a start bit.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // UART bit engine: mid-bit sampling after a half-bit start delay.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            ustate_reg     <= U_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_byte_reg    <= '0;
            byte_ready_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
        end else begin
            byte_ready_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
            case (ustate_reg)
                U_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        ustate_reg   <= U_START;
                        baud_cnt_reg <= '0;
                    end
                end
                U_START: begin
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        // A start bit that has gone high again was a glitch.
                        ustate_reg   <= rx_sync_reg ? U_IDLE : U_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 12'd1;
                    end
                end
                U_DATA: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            ustate_reg <= U_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 12'd1;
                    end
                end
                U_STOP: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        ustate_reg   <= U_IDLE;
                        if (rx_sync_reg) begin
                            rx_byte_reg    <= shift_reg;
                            byte_ready_reg <= 1'b1;
                        end else begin
                            stop_err_reg   <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 12'd1;
                    end
                end
                default: ustate_reg <= U_IDLE;
            endcase
        end
    end

    // Shadow capture array: each bit is written only when the index selects it.
    generate
        for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_shadow
            always_ff @(posedge clk100 or posedge reset) begin
                if (reset) begin
                    shadow_reg[gi] <= 1'b0;
                end else if (shadow_we && (idx_reg == 8'(gi))) begin
                    shadow_reg[gi] <= rx_byte_reg[0];
                end
            end
        end
    endgenerate

    // Frame parser: hunts for LF, collects characters, commits on CR LF.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            pstate_reg      <= P_HUNT;
            idx_reg         <= '0;
            count_reg       <= '0;
            frame_reg       <= '0;
            ones_reg        <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            err_code_reg    <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            if (stop_err_reg) begin
                if (pstate_reg != P_HUNT) begin
                    frame_err_reg <= 1'b1;
                    err_code_reg  <= 2'd0;
                    pstate_reg    <= P_HUNT;
                end
            end else if (byte_ready_reg) begin
                case (pstate_reg)
                    P_HUNT: begin
                        if (rx_byte_reg == CH_LF) begin
                            pstate_reg <= P_DATA;
                            idx_reg    <= '0;
                            count_reg  <= '0;
                        end
                    end
                    P_DATA: begin
                        if (is_data) begin
                            if (idx_reg == FB8) begin
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= 2'd2;
                                pstate_reg    <= P_HUNT;
                            end else begin
                                idx_reg   <= idx_reg + 8'd1;
                                count_reg <= count_reg + {7'd0, rx_byte_reg[0]};
                            end
                        end else if (rx_byte_reg == CH_CR) begin
                            if (idx_reg == FB8) begin
                                pstate_reg <= P_LFWAIT;
                            end else begin
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= 2'd2;
                                pstate_reg    <= P_HUNT;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= 2'd1;
                            pstate_reg    <= P_HUNT;
                        end
                    end
                    P_LFWAIT: begin
                        if (rx_byte_reg == CH_LF) begin
                            frame_reg       <= shadow_reg;
                            ones_reg        <= count_reg;
                            frame_valid_reg <= 1'b1;
                            pstate_reg      <= P_DATA;
                            idx_reg         <= '0;
                            count_reg       <= '0;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= 2'd3;
                            pstate_reg    <= P_HUNT;
                        end
                    end
                    default: pstate_reg <= P_HUNT;
                endcase
            end
        end
    end

    assign bus.rx_byte     = rx_byte_reg;
    assign bus.byte_ready  = byte_ready_reg;
    assign bus.frame       = frame_reg;
    assign bus.ones_count  = ones_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_err   = frame_err_reg;
    assign bus.err_code    = err_code_reg;
endmodule
